data_mem: RTL and testbench

Data-side memory responder for the pipelined RISC-V core. It answers the core's MEM-stage load/store requests from an on-chip word RAM, and also decodes a small MMIO window. That window holds a 64-bit machine timer with compare interrupt, a 4-entry UART transmit FIFO, and a simulation tohost register. It sits directly on the core's `mem_load`/`mem_store`/`address`/`store_data`/`load_data` pins; the core has no stall input, so the responder is zero-wait.

---
 rtl/mem_map_pkg.sv | 36 +++
 rtl/data_mem_sync_fifo.sv | 49 ++++
 rtl/data_mem.sv | 128 ++++++++++++
 tb/tb_data_mem.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// Shared address map for the data-side responder: MMIO window base, register
// offsets and UART status bit layout.
package mem_map_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h1000_0000;

  typedef enum logic [4:0] {
    MTIME_LO    = 5'h00,
    MTIME_HI    = 5'h04,
    MTIMECMP_LO = 5'h08,
    MTIMECMP_HI = 5'h0C,
    UART_TX     = 5'h10,
    TOHOST      = 5'h14,
    RSVD_18     = 5'h18,
    RSVD_1C     = 5'h1C
  } mmio_off_e;

  localparam int unsigned UART_ST_OVERFLOW  = 31;
  localparam int unsigned UART_ST_FULL      = 4;
  localparam int unsigned UART_ST_EMPTY     = 3;
  localparam int unsigned UART_ST_COUNT_LSB = 0;

  function automatic logic [31:0] uart_status(input logic       overflow,
                                              input logic       full,
                                              input logic       empty,
                                              input logic [2:0] count);
    logic [31:0] st;
    st = '0;
    st[UART_ST_OVERFLOW]                        = overflow;
    st[UART_ST_FULL]                            = full;
    st[UART_ST_EMPTY]                           = empty;
    st[UART_ST_COUNT_LSB+2:UART_ST_COUNT_LSB]   = count;
    return st;
  endfunction

endpackage

// File: rtl/data_mem_sync_fifo.sv
// Small synchronous FIFO with simultaneous push/pop; a push while full is
// accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/data_mem.sv
// Zero-wait data memory responder: word RAM plus MMIO window holding the
// machine timer, UART transmit FIFO and simulation tohost register.
module data_mem
  import mem_map_pkg::*;
#(
  parameter int unsigned      XLEN        = 32,
  parameter int unsigned      DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0]  MMIO_BASE   = MMIO_BASE_DEFAULT,
  parameter                   INIT_FILE   = ""
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            mem_load,
  input  logic            mem_store,
  input  logic [XLEN-1:0] address,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] load_data,
  output logic            timer_irq,
  output logic            uart_tx_valid,
  output logic [7:0]      uart_tx_data,
  input  logic            uart_tx_ready,
  output logic            tohost_valid,
  output logic [XLEN-1:0] tohost_data
);

  localparam int unsigned     AW        = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-1:0] RAM_BYTES = XLEN'(DEPTH_WORDS * 4);

  logic [XLEN-1:0]   ram [DEPTH_WORDS];
  logic [AW-1:0]     ram_idx;
  logic              ram_hit;
  logic              mmio_hit;
  logic              mmio_wr;
  mmio_off_e         off;

  logic [2*XLEN-1:0] mtime;
  logic [2*XLEN-1:0] mtimecmp;

  logic              uart_push;
  logic              uart_pop;
  logic              uart_rd;
  logic              uart_full;
  logic              uart_empty;
  logic [2:0]        uart_count;
  logic              uart_overflow;

  assign ram_hit  = (address < RAM_BYTES);
  assign mmio_hit = (address[XLEN-1:5] == MMIO_BASE[XLEN-1:5]);
  assign ram_idx  = address[AW+1:2];
  assign off      = mmio_off_e'({address[4:2], 2'b00});
  assign mmio_wr  = mem_store && mmio_hit;

  // RAM is not reset, but a store coinciding with reset is still discarded.
  always_ff @(posedge clock) begin
    if (!reset && mem_store && ram_hit) ram[ram_idx] <= store_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mtime     <= '0;
      mtimecmp  <= '1;
      timer_irq <= 1'b0;
    end else begin
      timer_irq <= (mtime >= mtimecmp);
      // A half-write replaces the increment; the other half holds without carry.
      if (mmio_wr && off == MTIME_LO)      mtime[XLEN-1:0]      <= store_data;
      else if (mmio_wr && off == MTIME_HI) mtime[2*XLEN-1:XLEN] <= store_data;
      else                                 mtime                <= mtime + (2*XLEN)'(1);
      if (mmio_wr && off == MTIMECMP_LO) mtimecmp[XLEN-1:0]      <= store_data;
      if (mmio_wr && off == MTIMECMP_HI) mtimecmp[2*XLEN-1:XLEN] <= store_data;
    end
  end

  assign uart_push     = mmio_wr && off == UART_TX;
  assign uart_pop      = uart_tx_valid && uart_tx_ready;
  assign uart_rd       = mem_load && !mem_store && mmio_hit && off == UART_TX;
  assign uart_tx_valid = !uart_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (4)
  ) u_uart_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (uart_push),
    .push_data (store_data[7:0]),
    .pop       (uart_pop),
    .head_data (uart_tx_data),
    .full      (uart_full),
    .empty     (uart_empty),
    .count     (uart_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                     uart_overflow <= 1'b0;
    else if (uart_rd)                              uart_overflow <= 1'b0;
    else if (uart_push && uart_full && !uart_pop)  uart_overflow <= 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tohost_valid <= 1'b0;
      tohost_data  <= '0;
    end else if (mmio_wr && off == TOHOST) begin
      tohost_valid <= 1'b1;
      tohost_data  <= store_data;
    end
  end

  always_comb begin
    load_data = '0;
    if (ram_hit) begin
      load_data = ram[ram_idx];
    end else if (mmio_hit) begin
      case (off)
        MTIME_LO:    load_data = mtime[XLEN-1:0];
        MTIME_HI:    load_data = mtime[2*XLEN-1:XLEN];
        MTIMECMP_LO: load_data = mtimecmp[XLEN-1:0];
        MTIMECMP_HI: load_data = mtimecmp[2*XLEN-1:XLEN];
        UART_TX:     load_data = XLEN'(uart_status(uart_overflow, uart_full,
                                                   uart_empty, uart_count));
        TOHOST:      load_data = tohost_data;
        default:     load_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem: RAM, decode, timer, UART FIFO,
// tohost and asynchronous reset.
module tb_data_mem;

  localparam logic [31:0] MMIO      = 32'h1000_0000;
  localparam logic [31:0] A_MT_LO   = MMIO + 32'h00;
  localparam logic [31:0] A_MT_HI   = MMIO + 32'h04;
  localparam logic [31:0] A_CMP_LO  = MMIO + 32'h08;
  localparam logic [31:0] A_CMP_HI  = MMIO + 32'h0C;
  localparam logic [31:0] A_UART    = MMIO + 32'h10;
  localparam logic [31:0] A_TOHOST  = MMIO + 32'h14;
  localparam logic [31:0] A_RSVD    = MMIO + 32'h1C;

  logic        clock;
  logic        reset;
  logic        mem_load;
  logic        mem_store;
  logic [31:0] address;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        timer_irq;
  logic        uart_tx_valid;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_ready;
  logic        tohost_valid;
  logic [31:0] tohost_data;

  int tests;
  int fails;

  data_mem #(
    .XLEN        (32),
    .DEPTH_WORDS (1024),
    .MMIO_BASE   (MMIO)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .mem_load      (mem_load),
    .mem_store     (mem_store),
    .address       (address),
    .store_data    (store_data),
    .load_data     (load_data),
    .timer_irq     (timer_irq),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_ready (uart_tx_ready),
    .tohost_valid  (tohost_valid),
    .tohost_data   (tohost_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    address    = a;
    store_data = d;
    mem_store  = 1'b1;
    tick();
    mem_store  = 1'b0;
  endtask

  task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
    address  = a;
    mem_load = 1'b1;
    #1;
    chk(tag, load_data, exp);
    mem_load = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    mem_load = 1'b0;
    mem_store = 1'b0;
    address = '0;
    store_data = '0;
    uart_tx_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    chk("rst_irq", 32'(timer_irq), 32'd0);
    chk("rst_uart_valid", 32'(uart_tx_valid), 32'd0);
    chk("rst_tohost_valid", 32'(tohost_valid), 32'd0);
    chk("rst_tohost_data", tohost_data, 32'd0);
    tick();
    peek("rst_uart_status", A_UART, 32'h0000_0008);
    peek("rst_cmp_lo", A_CMP_LO, 32'hFFFF_FFFF);
    tick();

    // RAM round-trip, lane bits ignored, load+store treated as store
    store(32'h40, 32'hDEAD_BEEF);
    peek("ram_40", 32'h40, 32'hDEAD_BEEF);
    peek("ram_42", 32'h42, 32'hDEAD_BEEF);
    tick();
    mem_load = 1'b1;
    store(32'h48, 32'h1234_5678);
    peek("ram_ld_st", 32'h48, 32'h1234_5678);
    store(32'hFFC, 32'hA5A5_A5A5);
    peek("ram_last", 32'hFFC, 32'hA5A5_A5A5);
    store(32'h0, 32'h1111_1111);

    // Unmapped accesses
    store(32'h8000_0000, 32'hCAFE_F00D);
    store(32'h0000_1000, 32'h5A5A_5A5A);
    peek("unmap_hi_rd", 32'h8000_0000, 32'd0);
    peek("unmap_1000_rd", 32'h0000_1000, 32'd0);
    peek("ram0_intact", 32'h0, 32'h1111_1111);
    tick();
    store(A_RSVD, 32'hFFFF_FFFF);
    peek("mmio_rsvd", A_RSVD, 32'd0);
    peek("ram40_intact", 32'h40, 32'hDEAD_BEEF);

    // Timer compare
    store(A_MT_LO, 32'd0);
    store(A_CMP_LO, 32'd20);
    store(A_CMP_HI, 32'd0);
    store(A_MT_LO, 32'd0);
    repeat (19) tick();
    peek("mtime_19", A_MT_LO, 32'd19);
    chk("irq_at_19", 32'(timer_irq), 32'd0);
    tick();
    peek("mtime_20", A_MT_LO, 32'd20);
    chk("irq_at_20", 32'(timer_irq), 32'd0);
    tick();
    chk("irq_rise", 32'(timer_irq), 32'd1);
    store(A_CMP_LO, 32'hFFFF_FFFF);
    chk("irq_hold_cmp_wr", 32'(timer_irq), 32'd1);
    tick();
    chk("irq_fall", 32'(timer_irq), 32'd0);

    // Timer wrap
    store(A_MT_HI, 32'hFFFF_FFFF);
    store(A_MT_LO, 32'hFFFF_FFFE);
    tick();
    peek("wrap_lo_pre", A_MT_LO, 32'hFFFF_FFFF);
    peek("wrap_hi_pre", A_MT_HI, 32'hFFFF_FFFF);
    tick();
    peek("wrap_lo", A_MT_LO, 32'd0);
    peek("wrap_hi", A_MT_HI, 32'd0);

    // UART FIFO
    for (int i = 0; i < 5; i++) store(A_UART, 32'h41 + 32'(i));
    peek("uart_full_ovf", A_UART, 32'h8000_0014);
    chk("uart_head0", 32'(uart_tx_data), 32'h41);
    uart_tx_ready = 1'b1;
    store(A_UART, 32'h46);
    uart_tx_ready = 1'b0;
    peek("uart_pushpop_full", A_UART, 32'h8000_0014);
    address = A_UART;
    mem_load = 1'b1;
    tick();
    mem_load = 1'b0;
    peek("uart_ovf_clear", A_UART, 32'h0000_0014);
    uart_tx_ready = 1'b1;
    chk("uart_out0", 32'(uart_tx_data), 32'h42);
    tick();
    chk("uart_out1", 32'(uart_tx_data), 32'h43);
    tick();
    chk("uart_out2", 32'(uart_tx_data), 32'h44);
    tick();
    chk("uart_out3", 32'(uart_tx_data), 32'h46);
    chk("uart_valid_last", 32'(uart_tx_valid), 32'd1);
    tick();
    chk("uart_drained", 32'(uart_tx_valid), 32'd0);
    uart_tx_ready = 1'b0;
    peek("uart_empty_st", A_UART, 32'h0000_0008);
    tick();

    // Tohost and asynchronous reset
    store(A_UART, 32'h77);
    chk("uart_push_vis", 32'(uart_tx_valid), 32'd1);
    store(A_TOHOST, 32'd1);
    chk("tohost_valid", 32'(tohost_valid), 32'd1);
    chk("tohost_data", tohost_data, 32'd1);
    tick();
    tick();
    chk("tohost_valid_hold", 32'(tohost_valid), 32'd1);
    peek("tohost_rd", A_TOHOST, 32'd1);
    store(A_CMP_LO, 32'd0);
    tick();
    chk("irq_pre_reset", 32'(timer_irq), 32'd1);
    address    = A_TOHOST;
    store_data = 32'd5;
    mem_store  = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("areset_irq", 32'(timer_irq), 32'd0);
    chk("areset_uart_valid", 32'(uart_tx_valid), 32'd0);
    chk("areset_tohost_valid", 32'(tohost_valid), 32'd0);
    chk("areset_tohost_data", tohost_data, 32'd0);
    tick();
    mem_store = 1'b0;
    reset = 1'b0;
    chk("post_rst_tohost_valid", 32'(tohost_valid), 32'd0);
    chk("post_rst_tohost_data", tohost_data, 32'd0);
    peek("post_rst_uart_st", A_UART, 32'h0000_0008);
    peek("post_rst_cmp_hi", A_CMP_HI, 32'hFFFF_FFFF);
    peek("post_rst_mt_hi", A_MT_HI, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
